// File: rtl/grant_collector.sv
// Captures the single granted requester's data word, tags it with a source ID,
// and buffers it in a first-word-fall-through FIFO with drop and multi-grant fault tracking.
module grant_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gnt_a,
  input  logic                     gnt_b,
  input  logic                     gnt_c,
  input  logic [DATA_W-1:0]        data_a,
  input  logic [DATA_W-1:0]        data_b,
  input  logic [DATA_W-1:0]        data_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_src,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [7:0]               drop_cnt,
  output logic                     err_multi
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [1:0]        src;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    gnt_cnt;
  logic          push_req, multi, empty, pop, push, drop;
  entry_t        sel;

  assign gnt_cnt  = {1'b0, gnt_a} + {1'b0, gnt_b} + {1'b0, gnt_c};
  assign push_req = (gnt_cnt == 2'd1);
  assign multi    = gnt_cnt[1];

  always_comb begin
    sel = '0;
    if (gnt_a) begin
      sel.src  = 2'd1;
      sel.data = data_a;
    end else if (gnt_b) begin
      sel.src  = 2'd2;
      sel.data = data_b;
    end else if (gnt_c) begin
      sel.src  = 2'd3;
      sel.data = data_c;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign pop  = !empty && out_ready;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]].data;
  assign out_src   = empty ? '0 : mem[rd_ptr[AW-1:0]].src;

  // NOTE: storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sel;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      err_multi <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (multi) err_multi <= 1'b1;
    end
  end

endmodule
